// File: rtl/ascii_glyph_render_if.sv
// Handshake bundle between the density/edge stage, the glyph renderer and the pixel sink.
interface ascii_glyph_render_if #(
  parameter int unsigned TILE_WIDTH   = 8,
  parameter int unsigned TILE_HEIGHT  = 8,
  parameter int unsigned ASCII_LEVELS = 8,
  parameter int unsigned DATA_WIDTH   = 24
);
  logic [$clog2(ASCII_LEVELS)-1:0] ascii;
  logic                            edge_exists;
  logic                            ascii_ready;
  logic                            in_ready;
  logic [DATA_WIDTH-1:0]           pixel_data;
  logic                            pixel_valid;
  logic                            pixel_ready;
  logic [$clog2(TILE_WIDTH)-1:0]   px_x;
  logic [$clog2(TILE_HEIGHT)-1:0]  px_y;
  logic                            tile_last;
  logic                            overflow;

  modport master (
    output ascii, edge_exists, ascii_ready, pixel_ready,
    input  in_ready, pixel_data, pixel_valid, px_x, px_y, tile_last, overflow
  );

  modport slave (
    input  ascii, edge_exists, ascii_ready, pixel_ready,
    output in_ready, pixel_data, pixel_valid, px_x, px_y, tile_last, overflow
  );
endinterface

// File: rtl/ascii_glyph_render.sv
// Expands one density level / edge flag per tile into a row-major stream of glyph pixels.
module ascii_glyph_render #(
  parameter int unsigned TILE_WIDTH   = 8,
  parameter int unsigned TILE_HEIGHT  = 8,
  parameter int unsigned ASCII_LEVELS = 8,
  parameter int unsigned COLORS       = 3,
  parameter int unsigned COLOR_DEPTH  = 8,
  parameter int unsigned DATA_WIDTH   = COLORS * COLOR_DEPTH,
  parameter logic [DATA_WIDTH-1:0] FG_COLOR   = 24'hFFFFFF,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR   = 24'h000000,
  parameter logic [DATA_WIDTH-1:0] EDGE_COLOR = 24'h00FF00
) (
  input logic                 clk,
  input logic                 rst,
  ascii_glyph_render_if.slave bus
);
  localparam int unsigned XW = $clog2(TILE_WIDTH);
  localparam int unsigned YW = $clog2(TILE_HEIGHT);
  localparam int unsigned LW = $clog2(ASCII_LEVELS);
  localparam bit SinglePixel = (TILE_WIDTH * TILE_HEIGHT == 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                state_q;
  logic [XW-1:0]         px_x_q, nx;
  logic [YW-1:0]         px_y_q, ny;
  logic                  tile_last_q, nlast;
  logic [DATA_WIDTH-1:0] pixel_data_q;
  logic                  overflow_q;
  logic [LW-1:0]         level_q, level_in;
  logic                  edge_q;
  logic                  pixel_valid, in_ready, fire, accept;

  // 32-bit sum so x+y never wraps before the diagonal / modulo test.
  function automatic logic [DATA_WIDTH-1:0] glyph(input logic [LW-1:0] lvl,
                                                  input logic          edge_f,
                                                  input logic [XW-1:0] x,
                                                  input logic [YW-1:0] y);
    logic [31:0] sum;
    sum = 32'(x) + 32'(y);
    if (edge_f) begin
      return (sum == 32'(TILE_WIDTH - 1)) ? EDGE_COLOR : BG_COLOR;
    end
    return ((sum % 32'(ASCII_LEVELS)) < 32'(lvl)) ? FG_COLOR : BG_COLOR;
  endfunction

  assign level_in = (32'(bus.ascii) >= 32'(ASCII_LEVELS)) ? LW'(ASCII_LEVELS - 1) : bus.ascii;

  assign pixel_valid = (state_q == StEmit);
  assign fire        = pixel_valid && bus.pixel_ready;
  assign in_ready    = (state_q == StIdle) || (tile_last_q && pixel_valid && bus.pixel_ready);
  assign accept      = bus.ascii_ready && in_ready;

  always_comb begin
    nx = px_x_q + XW'(1);
    ny = px_y_q;
    if (px_x_q == XW'(TILE_WIDTH - 1)) begin
      nx = '0;
      ny = px_y_q + YW'(1);
    end
    nlast = (nx == XW'(TILE_WIDTH - 1)) && (ny == YW'(TILE_HEIGHT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      px_x_q       <= '0;
      px_y_q       <= '0;
      tile_last_q  <= 1'b0;
      pixel_data_q <= '0;
      overflow_q   <= 1'b0;
      level_q      <= '0;
      edge_q       <= 1'b0;
    end else begin
      if (bus.ascii_ready && !in_ready) begin
        overflow_q <= 1'b1;
      end
      if (accept) begin
        state_q      <= StEmit;
        level_q      <= level_in;
        edge_q       <= bus.edge_exists;
        px_x_q       <= '0;
        px_y_q       <= '0;
        tile_last_q  <= SinglePixel;
        pixel_data_q <= glyph(level_in, bus.edge_exists, XW'(0), YW'(0));
      end else if (fire) begin
        if (tile_last_q) begin
          state_q     <= StIdle;
          tile_last_q <= 1'b0;
          px_x_q      <= '0;
          px_y_q      <= '0;
        end else begin
          px_x_q       <= nx;
          px_y_q       <= ny;
          tile_last_q  <= nlast;
          pixel_data_q <= glyph(level_q, edge_q, nx, ny);
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.pixel_valid = pixel_valid;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.px_x        = px_x_q;
  assign bus.px_y        = px_y_q;
  assign bus.tile_last   = tile_last_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ascii_glyph_render.sv
// Randomised and directed stimulus checked cycle by cycle against a linear-index tile model.
module tb_ascii_glyph_render;
  localparam int W = 8;
  localparam int H = 8;
  localparam int L = 8;
  localparam int N = W * H;
  localparam logic [23:0] FG   = 24'hFFFFFF;
  localparam logic [23:0] BG   = 24'h000000;
  localparam logic [23:0] EDGE = 24'h00FF00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascii_glyph_render_if #(
    .TILE_WIDTH(W), .TILE_HEIGHT(H), .ASCII_LEVELS(L), .DATA_WIDTH(24)
  ) bus ();

  ascii_glyph_render dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a tile is a linear pixel index 0..N-1 while busy.
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_lvl  = 0;
  bit m_edge = 1'b0;
  bit m_ovf  = 1'b0;

  int hs_cnt   = 0;
  int edge_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_color(input int lvl, input bit e, input int x, input int y);
    if (e) return (x + y == W - 1) ? EDGE : BG;
    return (((x + y) % L) < lvl) ? FG : BG;
  endfunction

  // Called at posedge+1; applies inputs for this cycle, checks, advances model, waits one clock.
  task automatic cycle(input bit strobe, input int a, input bit e, input bit pr, input bit do_rst);
    bit exp_rdy;
    rst             = do_rst;
    bus.ascii_ready = strobe;
    bus.ascii       = 3'(a);
    bus.edge_exists = e;
    bus.pixel_ready = pr;
    #1;
    exp_rdy = !m_busy || (m_idx == N - 1 && pr);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("pixel_valid", 32'(bus.pixel_valid), 32'(m_busy));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_busy) begin
      chk("px_x", 32'(bus.px_x), 32'(m_idx % W));
      chk("px_y", 32'(bus.px_y), 32'(m_idx / W));
      chk("pixel_data", 32'(bus.pixel_data), 32'(ref_color(m_lvl, m_edge, m_idx % W, m_idx / W)));
      chk("tile_last", 32'(bus.tile_last), 32'(m_idx == N - 1));
    end else begin
      chk("tile_last_idle", 32'(bus.tile_last), 32'd0);
    end
    if (!do_rst && bus.pixel_valid && pr) begin
      hs_cnt++;
      if (bus.pixel_data == EDGE) edge_cnt++;
    end
    if (do_rst) begin
      m_busy = 1'b0; m_idx = 0; m_lvl = 0; m_edge = 1'b0; m_ovf = 1'b0;
    end else begin
      if (strobe && !exp_rdy) m_ovf = 1'b1;
      if (strobe && exp_rdy) begin
        m_busy = 1'b1; m_idx = 0; m_lvl = (a >= L) ? L - 1 : a; m_edge = e;
      end else if (m_busy && pr) begin
        if (m_idx == N - 1) m_busy = 1'b0;
        else m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int idx);
    int guard = 0;
    while (m_busy && m_idx != idx && guard < 1000) begin
      cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    if (m_idx != idx) chk("run_to_timeout", 32'(m_idx), 32'(idx));
  endtask

  task automatic finish_tile(input int ready_pct);
    int guard = 0;
    while (m_busy && guard < 2000) begin
      cycle(1'b0, 0, 1'b0, $urandom_range(0, 99) < ready_pct, 1'b0);
      guard++;
    end
    if (m_busy) chk("finish_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bus.ascii_ready = 1'b0;
    bus.ascii       = '0;
    bus.edge_exists = 1'b0;
    bus.pixel_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
    chk("rst_tile_last", 32'(bus.tile_last), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_px", {bus.px_x, bus.px_y}, 32'd0);
    chk("rst_pixel_data", 32'(bus.pixel_data), 32'd0);

    // Dense tile, continuous ready.
    hs_cnt = 0;
    cycle(1'b1, 7, 1'b0, 1'b1, 1'b0);
    repeat (N) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("dense_pixels", 32'(hs_cnt), 32'(N));
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Edge tile: anti-diagonal only.
    hs_cnt = 0; edge_cnt = 0;
    cycle(1'b1, 0, 1'b1, 1'b1, 1'b0);
    repeat (N) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("edge_pixels", 32'(hs_cnt), 32'(N));
    chk("edge_hits", 32'(edge_cnt), 32'(W));

    // Random backpressure.
    hs_cnt = 0;
    cycle(1'b1, 7, 1'b0, 1'b0, 1'b0);
    finish_tile(50);
    chk("stall_pixels", 32'(hs_cnt), 32'(N));

    // Back-to-back tiles: strobe on the last-pixel handshake.
    cycle(1'b1, 3, 1'b0, 1'b1, 1'b0);
    run_to(N - 1);
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b0);
    chk("b2b_valid", 32'(bus.pixel_valid), 32'd1);
    chk("b2b_overflow", 32'(bus.overflow), 32'd0);
    finish_tile(100);

    // Dropped strobe mid-tile, then reset clears overflow.
    cycle(1'b1, 6, 1'b0, 1'b1, 1'b0);
    run_to(10);
    cycle(1'b1, 2, 1'b1, 1'b1, 1'b0);
    chk("drop_overflow", 32'(bus.overflow), 32'd1);
    finish_tile(70);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Reset mid-tile aborts it.
    cycle(1'b1, 4, 1'b0, 1'b1, 1'b0);
    run_to(20);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk("abort_valid", 32'(bus.pixel_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    cycle(1'b1, 1, 1'b0, 1'b1, 1'b0);
    chk("restart_px", {bus.px_x, bus.px_y}, 32'd0);
    finish_tile(100);

    // Strobe coincident with reset is ignored.
    cycle(1'b1, 7, 1'b0, 1'b1, 1'b1);
    chk("rst_strobe_ignored", 32'(bus.pixel_valid), 32'd0);

    // Random soak.
    repeat (4000) begin
      cycle($urandom_range(0, 99) < 6, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 999) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
